// File: rtl/aclock_multi.sv
`default_nettype none
// ============================================================================
//  Module   : aclock_multi
//  Purpose  : 24-hour BCD clock with N alarm slots, ring timeout and optional
//             snooze (enabled by defining ACLOCK_SNOOZE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module aclock_multi #(
    parameter int CLK_PER_SEC = 10,
    parameter int N_ALARMS    = 4,
    parameter int SNOOZE_MIN  = 5,
    parameter int RING_SEC    = 60,
    localparam int AW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    H_in1,
    input  logic [3:0]    H_in0,
    input  logic [3:0]    M_in1,
    input  logic [3:0]    M_in0,
    input  logic          LD_time,
    input  logic          LD_alarm,
    input  logic          AL_CLR,
    input  logic [AW-1:0] AL_SEL,
    input  logic          AL_ON,
    input  logic          STOP_al,
    input  logic          SNOOZE,
    output logic          Alarm,
    output logic [AW-1:0] AL_ID,
    output logic          SEC_tick,
    output logic [1:0]    H_out1,
    output logic [3:0]    H_out0,
    output logic [3:0]    M_out1,
    output logic [3:0]    M_out0,
    output logic [3:0]    S_out1,
    output logic [3:0]    S_out0
);

    localparam int       PW     = $clog2(CLK_PER_SEC);
    localparam logic [7:0] RING_LD = 8'(RING_SEC);

`ifdef ACLOCK_SNOOZE_EN
    localparam logic [11:0] SNZ_LD = 12'(SNOOZE_MIN * 60);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RING    = 2'd1,
        S_SNOOZED = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RING = 1'b1
    } state_t;
    logic w_unused_snooze;
    assign w_unused_snooze = SNOOZE;
`endif

    logic [PW-1:0] presc_q;
    logic [1:0]    h1_q;
    logic [3:0]    h0_q, m1_q, m0_q, s1_q, s0_q;
    logic          sec_tick_q;

    logic [1:0]    al_h1_q [N_ALARMS];
    logic [3:0]    al_h0_q [N_ALARMS];
    logic [3:0]    al_m1_q [N_ALARMS];
    logic [3:0]    al_m0_q [N_ALARMS];
    logic [N_ALARMS-1:0] al_en_q;

    state_t        state_q, state_d;
    logic [7:0]    ring_q, ring_d;
    logic [AW-1:0] id_q, id_d;
    logic          alarm_q;
`ifdef ACLOCK_SNOOZE_EN
    logic [11:0]   snz_q, snz_d;
`endif

    logic          w_ld_ok, w_ld_time, w_tick, w_sec_adv, w_at_min, w_hit;
    logic [AW-1:0] w_hit_id;
    logic [1:0]    w_adv_h1;
    logic [3:0]    w_adv_h0, w_adv_m1, w_adv_m0, w_adv_s1, w_adv_s0;

    assign w_ld_ok   = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                       && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
    assign w_ld_time = LD_time && w_ld_ok;
    assign w_tick    = (presc_q == PW'(CLK_PER_SEC - 1));
    // A valid time load overrides a coincident second advance entirely.
    assign w_sec_adv = w_tick && !w_ld_time;
    assign w_at_min  = w_sec_adv && (w_adv_s1 == 4'd0) && (w_adv_s0 == 4'd0);

    always_comb begin
        w_adv_s0 = s0_q + 4'd1;
        w_adv_s1 = s1_q;
        w_adv_m0 = m0_q;
        w_adv_m1 = m1_q;
        w_adv_h0 = h0_q;
        w_adv_h1 = h1_q;
        if (s0_q == 4'd9) begin
            w_adv_s0 = 4'd0;
            if (s1_q == 4'd5) begin
                w_adv_s1 = 4'd0;
                w_adv_m0 = m0_q + 4'd1;
                if (m0_q == 4'd9) begin
                    w_adv_m0 = 4'd0;
                    if (m1_q == 4'd5) begin
                        w_adv_m1 = 4'd0;
                        if (h1_q == 2'd2 && h0_q == 4'd3) begin
                            w_adv_h1 = 2'd0;
                            w_adv_h0 = 4'd0;
                        end else if (h0_q == 4'd9) begin
                            w_adv_h0 = 4'd0;
                            w_adv_h1 = h1_q + 2'd1;
                        end else begin
                            w_adv_h0 = h0_q + 4'd1;
                        end
                    end else begin
                        w_adv_m1 = m1_q + 4'd1;
                    end
                end
            end else begin
                w_adv_s1 = s1_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= w_sec_adv;
            if (w_ld_time) begin
                presc_q <= '0;
                h1_q    <= H_in1;
                h0_q    <= H_in0;
                m1_q    <= M_in1;
                m0_q    <= M_in0;
                s1_q    <= 4'd0;
                s0_q    <= 4'd0;
            end else if (w_tick) begin
                presc_q <= '0;
                h1_q    <= w_adv_h1;
                h0_q    <= w_adv_h0;
                m1_q    <= w_adv_m1;
                m0_q    <= w_adv_m0;
                s1_q    <= w_adv_s1;
                s0_q    <= w_adv_s0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Out-of-range AL_SEL matches no slot index, so the write falls away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ALARMS; i++) begin
            if (reset) begin
                al_en_q[i] <= 1'b0;
                al_h1_q[i] <= 2'd0;
                al_h0_q[i] <= 4'd0;
                al_m1_q[i] <= 4'd0;
                al_m0_q[i] <= 4'd0;
            end else if (AL_SEL == AW'(i)) begin
                if (AL_CLR) begin
                    al_en_q[i] <= 1'b0;
                end else if (LD_alarm && w_ld_ok) begin
                    al_en_q[i] <= 1'b1;
                    al_h1_q[i] <= H_in1;
                    al_h0_q[i] <= H_in0;
                    al_m1_q[i] <= M_in1;
                    al_m0_q[i] <= M_in0;
                end
            end
        end
    end

    // Descending scan leaves the lowest matching index as the winner.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_at_min && al_en_q[i] &&
                al_h1_q[i] == w_adv_h1 && al_h0_q[i] == w_adv_h0 &&
                al_m1_q[i] == w_adv_m1 && al_m0_q[i] == w_adv_m0) begin
                w_hit    = 1'b1;
                w_hit_id = AW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        id_d    = id_q;
`ifdef ACLOCK_SNOOZE_EN
        snz_d   = snz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (AL_ON && w_hit) begin
                    state_d = S_RING;
                    ring_d  = RING_LD;
                    id_d    = w_hit_id;
                end
            end
            S_RING: begin
                if (STOP_al || !AL_ON) begin
                    state_d = S_IDLE;
`ifdef ACLOCK_SNOOZE_EN
                end else if (SNOOZE) begin
                    state_d = S_SNOOZED;
                    snz_d   = SNZ_LD;
`endif
                end else if (w_sec_adv) begin
                    ring_d = ring_q - 8'd1;
                    if (ring_q <= 8'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef ACLOCK_SNOOZE_EN
            S_SNOOZED: begin
                if (STOP_al || !AL_ON) begin
                    state_d = S_IDLE;
                end else if (w_sec_adv) begin
                    snz_d = snz_q - 12'd1;
                    if (snz_q <= 12'd1) begin
                        state_d = S_RING;
                        ring_d  = RING_LD;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ring_q  <= 8'd0;
            id_q    <= '0;
            alarm_q <= 1'b0;
`ifdef ACLOCK_SNOOZE_EN
            snz_q   <= 12'd0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            id_q    <= id_d;
            alarm_q <= (state_d == S_RING);
`ifdef ACLOCK_SNOOZE_EN
            snz_q   <= snz_d;
`endif
        end
    end

    assign Alarm    = alarm_q;
    assign AL_ID    = id_q;
    assign SEC_tick = sec_tick_q;
    assign H_out1   = h1_q;
    assign H_out0   = h0_q;
    assign M_out1   = m1_q;
    assign M_out0   = m0_q;
    assign S_out1   = s1_q;
    assign S_out0   = s0_q;

endmodule
`default_nettype wire

// File: tb/tb_aclock_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aclock_multi
//  Purpose  : Directed scoreboard bench for aclock_multi (10 clk/s, 4 slots,
//             1 min snooze, 5 s ring).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aclock_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, AL_CLR, AL_ON, STOP_al, SNOOZE;
    logic [1:0] AL_SEL;
    logic       Alarm, SEC_tick;
    logic [1:0] AL_ID;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;
    int tick_base;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;
    exp_t sbq[$];

    aclock_multi #(
        .CLK_PER_SEC (10),
        .N_ALARMS    (4),
        .SNOOZE_MIN  (1),
        .RING_SEC    (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .AL_CLR   (AL_CLR),
        .AL_SEL   (AL_SEL),
        .AL_ON    (AL_ON),
        .STOP_al  (STOP_al),
        .SNOOZE   (SNOOZE),
        .Alarm    (Alarm),
        .AL_ID    (AL_ID),
        .SEC_tick (SEC_tick),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (SEC_tick === 1'b1) ticks++;

    function automatic logic [24:0] pack_exp(input int h, input int m, input int s,
                                             input logic al, input logic [1:0] id);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), al, id};
    endfunction

    task automatic push(input string tag, input int h, input int m, input int s,
                        input logic al, input logic [1:0] id);
        exp_t e;
        e.tag = tag;
        e.v   = pack_exp(h, m, s, al, id);
        sbq.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t        e;
        logic [24:0] obs;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed no expectation, expected a queued entry");
        end else begin
            e   = sbq.pop_front();
            obs = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm, AL_ID};
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %0h%0h:%0h%0h:%0h%0h alarm=%b id=%0d, expected %0h%0h:%0h%0h:%0h%0h alarm=%b id=%0d",
                       e.tag, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm, AL_ID,
                       e.v[24:23], e.v[22:19], e.v[18:15], e.v[14:11], e.v[10:7], e.v[6:3],
                       e.v[2], e.v[1:0]);
            end
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hm(input int h, input int m);
        H_in1 = 2'(h / 10);
        H_in0 = 4'(h % 10);
        M_in1 = 4'(m / 10);
        M_in0 = 4'(m % 10);
    endtask

    task automatic ld_time(input int h, input int m);
        set_hm(h, m);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input logic [1:0] sel, input int h, input int m, input logic clr);
        set_hm(h, m);
        AL_SEL   = sel;
        LD_alarm = 1'b1;
        AL_CLR   = clr;
        cyc(1);
        LD_alarm = 1'b0;
        AL_CLR   = 1'b0;
    endtask

    task automatic al_clr(input logic [1:0] sel);
        AL_SEL = sel;
        AL_CLR = 1'b1;
        cyc(1);
        AL_CLR = 1'b0;
    endtask

    initial begin
        reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; AL_CLR = 1'b0; AL_SEL = 2'd0;
        AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
        set_hm(0, 0);
        cyc(3);
        push("reset", 0, 0, 0, 1'b0, 2'd0);
        pop_chk();
        cmp_int("reset_tick", int'(SEC_tick), 0);
        reset = 1'b0;

        // Load and count one minute
        push("load_1234", 12, 34, 0, 1'b0, 2'd0);
        ld_time(12, 34);
        pop_chk();
        tick_base = ticks;
        push("count_600", 12, 35, 0, 1'b0, 2'd0);
        cyc(600);
        pop_chk();
        cmp_int("tick_pulse", int'(SEC_tick), 1);
        cyc(1);
        cmp_int("tick_count", ticks - tick_base, 60);
        cmp_int("tick_low", int'(SEC_tick), 0);

        // Day wrap and rejected loads
        push("wrap", 0, 0, 0, 1'b0, 2'd0);
        ld_time(23, 59);
        cyc(600);
        pop_chk();
        push("bad_hour", 0, 0, 0, 1'b0, 2'd0);
        ld_time(24, 0);
        pop_chk();
        push("bad_min", 0, 0, 0, 1'b0, 2'd0);
        ld_time(12, 60);
        pop_chk();

        // Slots: 0 cleared by coincident LD+CLR, 1 and 3 armed, 2 cleared
        AL_ON = 1'b1;
        ld_alarm(2'd0, 12, 35, 1'b0);
        ld_alarm(2'd0, 12, 35, 1'b1);
        ld_alarm(2'd1, 12, 35, 1'b0);
        ld_alarm(2'd3, 12, 35, 1'b0);
        ld_alarm(2'd2, 12, 35, 1'b0);
        al_clr(2'd2);
        push("pre_match", 12, 34, 59, 1'b0, 2'd0);
        push("match", 12, 35, 0, 1'b1, 2'd1);
        ld_time(12, 34);
        cyc(599);
        pop_chk();
        cyc(1);
        pop_chk();

        // Stop
        push("ring_02", 12, 35, 2, 1'b1, 2'd1);
        cyc(20);
        pop_chk();
        push("stop", 12, 35, 2, 1'b0, 2'd1);
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
        pop_chk();
        push("after_stop", 12, 35, 7, 1'b0, 2'd1);
        cyc(50);
        pop_chk();

        // Timeout
        push("ring_b", 12, 35, 0, 1'b1, 2'd1);
        push("ring_b_04", 12, 35, 4, 1'b1, 2'd1);
        push("timeout", 12, 35, 5, 1'b0, 2'd1);
        ld_time(12, 34);
        cyc(600);
        pop_chk();
        cyc(49);
        pop_chk();
        cyc(1);
        pop_chk();

        // Slot 1 cleared: slot 3 rings; AL_ON drop ends the ring
        al_clr(2'd1);
        push("ring_slot3", 12, 35, 0, 1'b1, 2'd3);
        ld_time(12, 34);
        cyc(600);
        pop_chk();
        push("al_off", 12, 35, 0, 1'b0, 2'd3);
        AL_ON = 1'b0;
        cyc(1);
        pop_chk();

        // Master enable off: no ring
        push("off_no_ring", 12, 35, 0, 1'b0, 2'd3);
        push("off_later", 12, 35, 1, 1'b0, 2'd3);
        ld_time(12, 34);
        cyc(600);
        pop_chk();
        cyc(10);
        pop_chk();

        // Snooze
        AL_ON = 1'b1;
        ld_alarm(2'd1, 12, 35, 1'b0);
        push("ring_e", 12, 35, 0, 1'b1, 2'd1);
        push("ring_e_02", 12, 35, 2, 1'b1, 2'd1);
        ld_time(12, 34);
        cyc(600);
        pop_chk();
        cyc(20);
        pop_chk();
        SNOOZE = 1'b1;
`ifdef ACLOCK_SNOOZE_EN
        push("snoozed", 12, 35, 2, 1'b0, 2'd1);
        cyc(1);
        SNOOZE = 1'b0;
        pop_chk();
        push("snooze_wait", 12, 36, 1, 1'b0, 2'd1);
        cyc(598);
        pop_chk();
        push("re_ring", 12, 36, 2, 1'b1, 2'd1);
        cyc(1);
        pop_chk();
        push("snooze2", 12, 36, 2, 1'b0, 2'd1);
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
        pop_chk();
        push("stop_snz", 12, 36, 2, 1'b0, 2'd1);
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
        pop_chk();
        push("no_rering", 12, 37, 2, 1'b0, 2'd1);
        cyc(600);
        pop_chk();
`else
        push("snz_ignored", 12, 35, 2, 1'b1, 2'd1);
        cyc(1);
        SNOOZE = 1'b0;
        pop_chk();
        push("snz_off_04", 12, 35, 4, 1'b1, 2'd1);
        cyc(28);
        pop_chk();
        push("snz_off_to", 12, 35, 5, 1'b0, 2'd1);
        cyc(1);
        pop_chk();
`endif

        // Reset during a ring, then confirm slot enables were cleared
        push("ring_r", 12, 35, 0, 1'b1, 2'd1);
        ld_time(12, 34);
        cyc(600);
        pop_chk();
        push("reset_ring", 0, 0, 0, 1'b0, 2'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        pop_chk();
        push("post_reset", 12, 35, 0, 1'b0, 2'd0);
        ld_time(12, 34);
        cyc(600);
        pop_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aclock_multi.md
# aclock_multi

Parametrised successor to the single-alarm BCD clock. It keeps a 24-hour HH:MM:SS time in BCD, derived from a fast input clock by a configurable prescaler. It holds N independent alarm slots, each with its own enable, and rings through a small state machine. Ringing ends on stop, on auto-timeout, or on snooze. It sits between the user-input debounce/keypad logic and the display/buzzer drivers.

## Interface
- CLK_PER_SEC, 10: clk cycles per second; must be at least 2.
- N_ALARMS, 4: number of alarm slots, 1 to 16. AW = max(1, clog2(N_ALARMS)).
- SNOOZE_MIN, 5: snooze length in minutes, 1 to 59.
- RING_SEC, 60: auto-timeout of a ring in seconds, 1 to 255.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- H_in1  in  2  hour tens, BCD.
- H_in0  in  4  hour units, BCD.
- M_in1  in  4  minute tens, BCD.
- M_in0  in  4  minute units, BCD.
- LD_time  in  1  load H_in/M_in into current time.
- LD_alarm  in  1  load H_in/M_in into slot AL_SEL and set that slot's enable.
- AL_CLR  in  1  clear the enable of slot AL_SEL.
- AL_SEL  in  AW  slot index for LD_alarm and AL_CLR.
- AL_ON  in  1  global alarm master enable.
- STOP_al  in  1  stop ringing or snoozing.
- SNOOZE  in  1  snooze request.
- Alarm  out  1  buzzer drive; high while ringing.
- AL_ID  out  AW  index of the ringing or snoozed slot.
- SEC_tick  out  1  one-cycle pulse per elapsed second.
- H_out1  out  2  current hour tens, BCD.
- H_out0  out  4  current hour units, BCD.
- M_out1  out  4  current minute tens, BCD.
- M_out0  out  4  current minute units, BCD.
- S_out1  out  4  current second tens, BCD.
- S_out0  out  4  current second units, BCD.

## Operation
- **Reset:**
  - All time digits 0 (00:00:00) and prescaler 0.
  - All slot enables 0 and slot times 00:00.
  - Alarm=0, AL_ID=0, SEC_tick=0, state IDLE, all counters 0.
- **Prescaler:**
  - Counts 0..CLK_PER_SEC-1.
  - At the edge where it equals CLK_PER_SEC-1, it wraps to 0 and time advances by one second.
- **Time counting:**
  - BCD carry chain: S 59→00 carries to M; M 59→00 carries to H; 23:59:59→00:00:00.
- **Input validation:** a load is valid only if every digit is ≤9, H ≤ 23 and M ≤ 59. An invalid LD_time or LD_alarm is ignored entirely.
- **LD_time (valid):**
  - Loads H/M, sets seconds to 00 and prescaler to 0.
  - Takes priority over a same-cycle second advance.
  - A load never triggers an alarm match.
- **Slot writes:**
  - LD_alarm (valid) writes slot AL_SEL and sets its enable.
  - AL_CLR clears the enable of slot AL_SEL.
  - LD_alarm and AL_CLR in the same cycle on the same slot: AL_CLR wins.
  - AL_SEL ≥ N_ALARMS: the write is ignored.
  - LD_time and a slot write in the same cycle both take effect.
- **Match:**
  - Evaluated only on a second advance that lands on HH:MM:00.
  - Requires AL_ON=1, state IDLE, slot enabled, and slot HH:MM equal to the new time.
  - If several slots match, the lowest index wins; the others are dropped for that minute.
  - Matches in RING or SNOOZED are ignored.
- **State machine:**
  - IDLE → RING on a match. AL_ID takes the winning slot; the ring timer loads RING_SEC.
  - RING:
    - Alarm=1; the ring timer decrements on each second advance.
    - → IDLE on STOP_al, on AL_ON=0, or when the timer reaches 0.
    - → SNOOZED on SNOOZE; the snooze timer loads SNOOZE_MIN×60.
    - Priority: reset > STOP_al > AL_ON=0 > SNOOZE > timeout.
  - SNOOZED:
    - Alarm=0, AL_ID held; the snooze timer decrements on each second advance.
    - → RING when it reaches 0 (ring timer reloaded, same AL_ID).
    - → IDLE on STOP_al or AL_ON=0.
    - SNOOZE is ignored.
- **Slot edits during a ring:** clearing or reloading the ringing slot does not end RING or SNOOZED.
- **LD_time during a ring:** does not affect RING or SNOOZED timers beyond the prescaler reset.

## Timing
- All outputs are registered.
- Time outputs update at the advancing edge.
- SEC_tick is high for exactly the one cycle following each second advance. It is not asserted by LD_time.
- On a match, Alarm rises at the same edge at which the time outputs show HH:MM:00.
- STOP_al sampled high drops Alarm at that edge.
- Load-to-output latency is one edge.
- Ring timeout: Alarm falls at the edge of the RING_SEC-th second advance after entry.
- Reset asserted mid-ring clears everything at the next edge.

## Configuration
- **ACLOCK_SNOOZE_EN defined:**
  - SNOOZE input and the SNOOZED state behave as described.
- **ACLOCK_SNOOZE_EN undefined:**
  - The SNOOZE port is still present but ignored.
  - No SNOOZED state and no snooze timer are synthesised.
  - RING exits only via stop, AL_ON=0, timeout or reset.

## Test plan
All scenarios use CLK_PER_SEC=10, N_ALARMS=4, SNOOZE_MIN=1, RING_SEC=5.
- **Reset, load and count:** reset, LD_time 12:34, run 600 cycles → outputs 12:35:00; exactly 60 SEC_tick pulses.
- **Wrap:** LD_time 23:59, run 600 cycles → 00:00:00; then LD_time with H=24 → time unchanged.
- **Multi-slot priority:** slots 1 and 3 loaded with 12:35, AL_ON=1, time 12:34:59 advances → Alarm=1 at 12:35:00 with AL_ID=1; slot 2 cleared via AL_CLR never rings.
- **Stop and timeout:**
  - STOP_al one cycle during RING → Alarm=0 at that edge.
  - Without stop → Alarm falls at 12:35:05.
  - AL_ON=0 → Alarm never rises.
- **Snooze (ACLOCK_SNOOZE_EN defined):** SNOOZE at 12:35:02 → Alarm=0, AL_ID=1 held; Alarm re-rises at 12:36:02; STOP_al while SNOOZED → IDLE, no re-ring.
- **Snooze compiled out:** same stimulus with the macro undefined → SNOOZE ignored, Alarm stays high until 12:35:05.
